mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Main control FSM of the multi-cycle MIPS CPU.
- Sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through the IF/ID/EXE/MEM/WB steps.
- Drives aluop to the ALU control decoder: 0 = add, 1 = sub, 2 = decode by opcode.
- One instruction in flight at a time; memory accesses use a ready handshake.

Parameters:
CNT_W, 32, width of the performance counters (only used when MC_PERF_CNT_EN is defined)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
zero  in  1  ALU result == 0
sign  in  1  ALU result bit 31
mem_ready  in  1  memory completes the current read/write this cycle
state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC
pc_src  out  2  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = {PC[31:28],IR[25:0],2'b00}, 3 = rs
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
alu_src_a  out  2  ALU A operand: 0 = PC, 1 = rs, 2 = zero-extended sa
alu_src_b  out  2  ALU B operand: 0 = rt, 1 = const 4, 2 = extended imm, 3 = extended imm<<2
aluop  out  2  to ALU control decoder
ext_sel  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend
reg_write  out  1  register file write enable
reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = $31
wb_src  out  2  write data: 0 = ALUOut, 1 = memory data register, 2 = PC
halted  out  1  core stopped

Behaviour:
Opcode classes:
- R-type: add 000000, sub 000001, and 010000, sll 011000, slt 100111
- I-type: addiu 000010, andi 010001, ori 010010, xori 010011, slti 100110
- Memory: sw 110000, lw 110001
- Branch: beq 110100, bne 110101, bltz 110110
- Jump: j 111000, jr 111001, jal 111010
- halt: 111111
- Any other opcode is illegal.

Reset and output defaults:
- rst_n low (asynchronous) → state = IF, counters = 0.
- While rst_n is low every output is 0; mem_read rises only after reset is released.
- ext_sel is 0 for andi/ori/xori, 1 otherwise, in every state.
- Every output not listed for a state is 0.
- Outputs are combinational from state, opcode, zero, sign and mem_ready; only state and the counters are registered.

State sequence:
- IF:
  - Drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, aluop=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to ID; otherwise stay in IF.
- ID:
  - Drive alu_src_a=0, alu_src_b=3, aluop=0 (branch target is latched into ALUOut).
  - halt → HALT.
  - j → pc_write, pc_src=2 → IF.
  - jal → pc_write, pc_src=2, reg_write, reg_dst=2, wb_src=2 → IF. PC already holds PC+4, so $31 receives PC+4.
  - jr → pc_write, pc_src=3 → IF.
  - Illegal opcode → IF (executes as a nop).
  - Any other opcode → EXE.
- EXE:
  - R-type: alu_src_a=1 (sll uses 2), alu_src_b=0, aluop=2 → WB.
  - I-type: alu_src_a=1, alu_src_b=2, aluop=2 → WB.
  - lw/sw: alu_src_a=1, alu_src_b=2, aluop=0 → MEM.
  - Branch: alu_src_a=1, alu_src_b=0, aluop=1.
    - Taken when beq & zero, bne & !zero, or bltz & sign.
    - Taken → pc_write, pc_src=1. Next state is IF either way.
- MEM:
  - iord=1; lw drives mem_read, sw drives mem_write.
  - Hold the strobe until mem_ready=1.
  - Then lw → WB, sw → IF.
- WB:
  - reg_write=1.
  - R-type: reg_dst=1, wb_src=0. I-type: reg_dst=0, wb_src=0. lw: reg_dst=0, wb_src=1.
  - Next state is IF.
- HALT: halted=1, all strobes 0, stays in HALT until reset.

Latency (mem_ready tied high): jump 2 cycles, branch 3, store 4, ALU 4, load 5.

Boundary rules:
- mem_ready=0 in IF or MEM stretches the state indefinitely with the strobes held stable.
- mem_ready is ignored in all other states.
- Reset asserted mid-instruction drops strobes immediately; no partial register or memory write is guaranteed beyond that edge.

Optional Feature:
MC_PERF_CNT_EN
- Defined:
  - Adds ports instr_cnt out CNT_W and cycle_cnt out CNT_W.
  - cycle_cnt increments on every clock in which state != HALT.
  - instr_cnt increments on every transition into IF from ID, EXE, MEM or WB (includes illegal-opcode nops).
  - Both counters wrap modulo 2^CNT_W, freeze in HALT and reset to 0.
- Not defined: the ports and counters do not exist; the rest of the behaviour is unchanged.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 → state sequence IF, ID, EXE, WB, IF; aluop=2 in EXE; reg_write=1, reg_dst=1 in WB.
- lw (110001) with mem_ready low for 3 cycles in MEM → mem_read and iord held for 4 cycles; WB has wb_src=1; instruction takes 8 cycles total.
- beq with zero=1, then bne with zero=1 → first: pc_write=1, pc_src=1 in EXE; second: pc_write=0; both return to IF.
- jal (111010) in ID → pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_src=2 in the same cycle; next state IF.
- halt (111111) → HALT, halted=1, all strobes 0 for 20 cycles; rst_n pulsed low mid-cycle → state=IF asynchronously.
- MC_PERF_CNT_EN: three add instructions then halt → instr_cnt=3, cycle_cnt=14 (12 instruction cycles + IF + ID of halt); both frozen afterwards.

Source files
------------

// File: rtl/mc_main_control.sv
// mc_main_control: main control FSM of the multi-cycle MIPS core.
// Steps the shared datapath through IF/ID/EXE/MEM/WB, one instruction at a time.
// IF and MEM wait on the mem_ready handshake.
// Optional feature macro: MC_PERF_CNT_EN adds the instr_cnt and cycle_cnt performance counters.
module mc_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             ext_sel,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic             halted
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic is_r, is_sll, is_i, is_lw, is_sw, is_beq, is_bne, is_bltz;
    logic is_j, is_jal, is_jr, is_halt, is_zext, br_taken;

    // Opcode class decode; anything not matched falls out as illegal (nop).
    always_comb begin
        is_r    = 1'b0;
        is_sll  = (opcode == 6'b011000);
        is_i    = 1'b0;
        is_lw   = (opcode == 6'b110001);
        is_sw   = (opcode == 6'b110000);
        is_beq  = (opcode == 6'b110100);
        is_bne  = (opcode == 6'b110101);
        is_bltz = (opcode == 6'b110110);
        is_j    = (opcode == 6'b111000);
        is_jr   = (opcode == 6'b111001);
        is_jal  = (opcode == 6'b111010);
        is_halt = (opcode == 6'b111111);
        is_zext = 1'b0;
        case (opcode)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111: is_r = 1'b1;
            6'b000010, 6'b100110:                                  is_i = 1'b1;
            6'b010001, 6'b010010, 6'b010011: begin
                is_i    = 1'b1;
                is_zext = 1'b1;   // logical immediates are zero-extended
            end
            default: ;
        endcase
        br_taken = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);
    end

    // State register; reset lands in IF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Next state and control outputs; everything forced low while reset is held.
    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        aluop     = 2'd0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wb_src    = 2'd0;
        halted    = 1'b0;
        ext_sel   = rst_n & ~is_zext;
        state     = rst_n ? state_q : S_IF;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    // PC+4 is computed by the ALU while the fetch is outstanding.
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    // Branch target PC+(imm<<2) goes into ALUOut for use in EXE.
                    alu_src_b = 2'd3;
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else if (is_j || is_jal) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        if (is_jal) begin
                            // PC already holds PC+4, so it is the link value.
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_src    = 2'd2;
                        end
                        state_d = S_IF;
                    end else if (is_jr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                        state_d  = S_IF;
                    end else if (is_r || is_i || is_lw || is_sw || is_beq || is_bne || is_bltz) begin
                        state_d = S_EXE;
                    end else begin
                        state_d = S_IF;   // illegal opcode retires as a nop
                    end
                end
                S_EXE: begin
                    alu_src_a = 2'd1;
                    if (is_r) begin
                        alu_src_a = is_sll ? 2'd2 : 2'd1;
                        aluop     = 2'd2;
                        state_d   = S_WB;
                    end else if (is_i) begin
                        alu_src_b = 2'd2;
                        aluop     = 2'd2;
                        state_d   = S_WB;
                    end else if (is_lw || is_sw) begin
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end else begin
                        // Branch compare: rs - rt sets zero/sign.
                        aluop   = 2'd1;
                        state_d = S_IF;
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    if (mem_ready) state_d = is_lw ? S_WB : S_IF;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = is_r ? 2'd1 : 2'd0;
                    wb_src    = is_lw ? 2'd1 : 2'd0;
                    state_d   = S_IF;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic retire;
    assign retire = (state_d == S_IF) &&
                    (state_q == S_ID || state_q == S_EXE || state_q == S_MEM || state_q == S_WB);

    // Performance counters: cycles outside HALT and retired instructions; both freeze in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state_q != S_HALT) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: scoreboard bench for mc_main_control.
// Instructions are expanded into per-cycle stimulus and expected control vectors.
// The driver replays the stimulus after each rising edge.
// The monitor pops the expected vector at each falling edge and compares it with the DUT outputs.
module tb_mc_main_control;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
    localparam int C_J = 5, C_JAL = 6, C_JR = 7, C_HALT = 8, C_ILL = 9;

    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       ext_sel;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        logic       rst_n;
        logic [5:0] opcode;
        logic       zero;
        logic       sign;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] icnt;
        logic [31:0] ccnt;
    } exp_t;

    logic clk, rst_n, zero, sign, mem_ready;
    logic [5:0] opcode;
    logic [2:0] state;
    logic ir_write, pc_write, iord, mem_read, mem_write, ext_sel, reg_write, halted;
    logic [1:0] pc_src, alu_src_a, alu_src_b, aluop, reg_dst, wb_src;
`ifdef MC_PERF_CNT_EN
    logic [31:0] instr_cnt, cycle_cnt;
`endif

    mc_main_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .state(state), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .ext_sel(ext_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src), .halted(halted)
`ifdef MC_PERF_CNT_EN
        , .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    m_ins, m_cyc;
    int    n_vec, n_bad;

    logic [5:0] legal [18] = '{6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111,
                               6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110,
                               6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110,
                               6'b111000, 6'b111001, 6'b111010};

    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b011000, 6'b100111: return C_R;
            6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110: return C_I;
            6'b110001: return C_LD;
            6'b110000: return C_ST;
            6'b110100, 6'b110101, 6'b110110: return C_BR;
            6'b111000: return C_J;
            6'b111010: return C_JAL;
            6'b111001: return C_JR;
            6'b111111: return C_HALT;
            default:   return C_ILL;
        endcase
    endfunction

    // Record one cycle: stimulus plus expected outputs and counter values seen that cycle.
    function automatic void push(input stim_t s, input ctl_t c, input bit ends);
        exp_t e;
        if (!s.rst_n) begin
            c = '0;
            m_ins = 0;
            m_cyc = 0;
        end else begin
            c.ext_sel = !(s.opcode inside {6'b010001, 6'b010010, 6'b010011});
        end
        e.ctl  = c;
        e.icnt = m_ins;
        e.ccnt = m_cyc;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (s.rst_n) begin
            if (c.state != 3'd5) m_cyc++;
            if (ends) m_ins++;
        end
    endfunction

    function automatic stim_t rnd(input logic [5:0] op);
        stim_t s;
        s.rst_n     = 1'b1;
        s.opcode    = op;
        s.zero      = 1'($urandom_range(0, 1));
        s.sign      = 1'($urandom_range(0, 1));
        s.mem_ready = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Expand one instruction into its cycle-by-cycle expectations.
    function automatic void gen_instr(input logic [5:0] op, input int w_if, input int w_mem,
                                      input logic z, input logic sg);
        ctl_t c;
        stim_t s;
        int k = cls(op);
        bit taken;
        for (int i = 0; i <= w_if; i++) begin
            s = rnd(op);
            s.mem_ready = (i == w_if);
            c = '0;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'd1;
            c.ir_write  = s.mem_ready;
            c.pc_write  = s.mem_ready;
            push(s, c, 1'b0);
        end
        s = rnd(op);
        c = '0;
        c.state = 3'd1;
        c.alu_src_b = 2'd3;
        case (k)
            C_HALT: begin push(s, c, 1'b0); return; end
            C_ILL:  begin push(s, c, 1'b1); return; end
            C_J, C_JAL, C_JR: begin
                c.pc_write = 1'b1;
                c.pc_src   = (k == C_JR) ? 2'd3 : 2'd2;
                if (k == C_JAL) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 2'd2;
                    c.wb_src    = 2'd2;
                end
                push(s, c, 1'b1);
                return;
            end
            default: push(s, c, 1'b0);
        endcase
        s = rnd(op);
        s.zero = z;
        s.sign = sg;
        c = '0;
        c.state = 3'd2;
        c.alu_src_a = 2'd1;
        if (k == C_R) begin
            if (op == 6'b011000) c.alu_src_a = 2'd2;
            c.aluop = 2'd2;
        end else if (k == C_I) begin
            c.alu_src_b = 2'd2;
            c.aluop = 2'd2;
        end else if (k == C_LD || k == C_ST) begin
            c.alu_src_b = 2'd2;
        end else begin
            c.aluop = 2'd1;
            taken = (op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && sg);
            c.pc_write = taken;
            c.pc_src   = taken ? 2'd1 : 2'd0;
            push(s, c, 1'b1);
            return;
        end
        push(s, c, 1'b0);
        if (k == C_LD || k == C_ST) begin
            for (int i = 0; i <= w_mem; i++) begin
                s = rnd(op);
                s.mem_ready = (i == w_mem);
                c = '0;
                c.state     = 3'd3;
                c.iord      = 1'b1;
                c.mem_read  = (k == C_LD);
                c.mem_write = (k == C_ST);
                push(s, c, (k == C_ST) && (i == w_mem));
            end
            if (k == C_ST) return;
        end
        s = rnd(op);
        c = '0;
        c.state     = 3'd4;
        c.reg_write = 1'b1;
        c.reg_dst   = (k == C_R) ? 2'd1 : 2'd0;
        c.wb_src    = (k == C_LD) ? 2'd1 : 2'd0;
        push(s, c, 1'b1);
    endfunction

    // Sit in HALT for n cycles with arbitrary inputs, then pulse reset for one cycle.
    function automatic void gen_halt(input int n);
        ctl_t c;
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd(6'($urandom_range(0, 63)));
            c = '0;
            c.state  = 3'd5;
            c.halted = 1'b1;
            push(s, c, 1'b0);
        end
        s = rnd(6'b111111);
        s.rst_n = 1'b0;
        push(s, '0, 1'b0);
    endfunction

    // Build the stimulus program, then replay it one cycle per rising edge.
    initial begin
        stim_t s;
        logic [5:0] op;
        m_ins = 0;
        m_cyc = 0;
        rst_n = 1'b0;
        opcode = '0;
        zero = 1'b0;
        sign = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = rnd(6'($urandom_range(0, 63)));
            s.rst_n = 1'b0;
            push(s, '0, 1'b0);
        end
        // Three adds then halt: 14 counted cycles, 3 retired instructions.
        for (int i = 0; i < 3; i++) gen_instr(6'b000000, 0, 0, 1'b0, 1'b0);
        gen_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        gen_halt(20);
        gen_instr(6'b110001, 0, 3, 1'b0, 1'b0);   // lw stalled 3 cycles in MEM
        gen_instr(6'b110100, 0, 0, 1'b1, 1'b0);   // beq taken
        gen_instr(6'b110101, 0, 0, 1'b1, 1'b0);   // bne not taken
        gen_instr(6'b110110, 1, 0, 1'b0, 1'b1);   // bltz taken after fetch stall
        gen_instr(6'b111010, 0, 0, 1'b0, 1'b0);   // jal
        gen_instr(6'b111001, 0, 0, 1'b0, 1'b0);   // jr
        gen_instr(6'b011000, 0, 0, 1'b0, 1'b0);   // sll uses sa as A operand
        gen_instr(6'b010010, 0, 0, 1'b0, 1'b0);   // ori, zero-extended
        gen_instr(6'b000111, 0, 0, 1'b0, 1'b0);   // illegal -> nop
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                op = legal[$urandom_range(0, 17)];
            end else begin
                op = 6'($urandom_range(0, 62));
            end
            gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        gen_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        gen_halt(5);

        while (stim_q.size() > 0) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            rst_n     = s.rst_n;
            opcode    = s.opcode;
            zero      = s.zero;
            sign      = s.sign;
            mem_ready = s.mem_ready;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard at every falling edge.
    initial begin
        exp_t e;
        ctl_t act;
        int cyc;
        n_vec = 0;
        n_bad = 0;
        cyc = 0;
        #1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            act = {state, ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_a,
                   alu_src_b, aluop, ext_sel, reg_write, reg_dst, wb_src, halted};
            n_vec++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl cycle %0d opcode %b: got %h expected %h (state got %0d exp %0d)",
                         cyc, opcode, act, e.ctl, act.state, e.ctl.state);
            end
`ifdef MC_PERF_CNT_EN
            n_vec++;
            if (instr_cnt !== e.icnt || cycle_cnt !== e.ccnt) begin
                n_bad++;
                $display("FAIL perf_cnt cycle %0d: got instr %0d cycle %0d expected instr %0d cycle %0d",
                         cyc, instr_cnt, cycle_cnt, e.icnt, e.ccnt);
            end
`endif
            cyc++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
